// File: rtl/dmem_access_unit.sv
// ---------------------------------------------------------------------------
// dmem_access_unit
//
// Memory-stage front end placed directly in front of the 128x32 data memory.
// Every CPU load/store address is decoded against the internal data memory
// window. Hits go straight to the data memory with no added latency. Misses
// become a start/done handshake on the external bus, with the pipeline held
// until the slave answers or the wait times out.
//
// Ports
//   clk        in   1   single clock, rising edge
//   reset_n    in   1   asynchronous active-low reset
//   cpu_addr   in  32   word address from the memory stage
//   cpu_data   in  32   store data
//   cpu_we     in   1   store request (wins when cpu_re is also high)
//   cpu_re     in   1   load request
//   cpu_q      out 32   load result to writeback
//   cpu_stall  out  1   freeze pipeline
//   bus_error  out  1   one-cycle timeout flag, valid in DONE
//   dmem_addr  out 32   data memory address (pass-through of cpu_addr)
//   dmem_we    out  1   data memory write enable (hits only)
//   dmem_data  out 32   data memory write data (pass-through of cpu_data)
//   dmem_q     in  32   data memory read data (combinational, write bypass)
//   bus_addr   out 32   external address, registered at capture
//   bus_data   out 32   external write data, registered at capture
//   bus_we     out  1   external write flag, registered at capture
//   bus_start  out  1   one-cycle transaction start
//   bus_done   in   1   transaction complete
//   bus_q      in  32   external read data, valid with bus_done
//
// State table
//   state    | meaning
//   ---------+----------------------------------------------------------
//   IDLE     | hits served combinationally; a miss is captured here
//   BUS_REQ  | bus_start pulses, timeout counter cleared
//   BUS_WAIT | waiting for bus_done or for the timeout to expire
//   DONE     | result presented to the CPU for one cycle, stall released
// ---------------------------------------------------------------------------
module dmem_access_unit #(
  parameter logic [31:0] DMEM_BASE   = 32'h0000_0000,
  parameter int          DMEM_AW     = 7,
  parameter int          BUS_TIMEOUT = 1023
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_data,
  input  logic        cpu_we,
  input  logic        cpu_re,
  output logic [31:0] cpu_q,
  output logic        cpu_stall,
  output logic        bus_error,
  output logic [31:0] dmem_addr,
  output logic        dmem_we,
  output logic [31:0] dmem_data,
  input  logic [31:0] dmem_q,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_data,
  output logic        bus_we,
  output logic        bus_start,
  input  logic        bus_done,
  input  logic [31:0] bus_q
);

  localparam int CW = $clog2(BUS_TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(BUS_TIMEOUT - 1);
  localparam logic [CW-1:0] CNT_SAT  = {CW{1'b1}};

  typedef enum logic [1:0] {
    IDLE,
    BUS_REQ,
    BUS_WAIT,
    DONE
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [31:0]   result;
  logic          hit;
  logic          req;

  assign hit = (cpu_addr[31:DMEM_AW] == DMEM_BASE[31:DMEM_AW]);
  assign req = cpu_we | cpu_re;

  assign dmem_addr = cpu_addr;
  assign dmem_data = cpu_data;

  // The combinational outputs are qualified with reset_n so that they drop
  // the moment reset is asserted, even while a request sits on the inputs.
  assign dmem_we = reset_n & cpu_we & hit & (state == IDLE);

  always_comb begin
    cpu_stall = 1'b0;
    cpu_q     = result;
    case (state)
      IDLE: begin
        cpu_stall = reset_n & req & ~hit;
        cpu_q     = dmem_q;
      end
      BUS_REQ:  cpu_stall = reset_n;
      BUS_WAIT: cpu_stall = reset_n;
      DONE:     cpu_stall = 1'b0;
      default:  cpu_stall = 1'b0;
    endcase
  end

  // bus_error doubles as the timeout flag: it is only ever set on the
  // transition into DONE and is cleared when DONE is left.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      bus_start <= 1'b0;
      bus_we    <= 1'b0;
      bus_addr  <= '0;
      bus_data  <= '0;
      result    <= '0;
      cnt       <= '0;
      bus_error <= 1'b0;
    end else begin
      bus_start <= 1'b0;
      case (state)
        IDLE: begin
          if (req && !hit) begin
            bus_addr  <= cpu_addr;
            bus_data  <= cpu_data;
            bus_we    <= cpu_we;
            bus_start <= 1'b1;
            state     <= BUS_REQ;
          end
        end
        BUS_REQ: begin
          cnt   <= '0;
          state <= BUS_WAIT;
        end
        BUS_WAIT: begin
          if (bus_done) begin
            result <= bus_we ? 32'h0 : bus_q;
            state  <= DONE;
          end else if (cnt == CNT_LAST) begin
            result    <= '0;
            bus_error <= 1'b1;
            state     <= DONE;
          end else if (cnt != CNT_SAT) begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE: begin
          // A request still on the inputs here is the one just served.
          bus_error <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_access_unit.sv
module tb_dmem_access_unit;

  localparam int T = 8;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [31:0] cpu_addr, cpu_data;
  logic        cpu_we, cpu_re;
  logic [31:0] cpu_q;
  logic        cpu_stall, bus_error;
  logic [31:0] dmem_addr, dmem_data, dmem_q;
  logic        dmem_we;
  logic [31:0] bus_addr, bus_data, bus_q;
  logic        bus_we, bus_start, bus_done;

  int checks = 0;
  int errors = 0;

  logic [31:0] ram     [128];
  logic [31:0] ref_mem [128];

  always #5 clk = ~clk;

  // Data memory stand-in: synchronous write, combinational read with bypass.
  always @(posedge clk) if (dmem_we) ram[dmem_addr[6:0]] <= dmem_data;
  assign dmem_q = dmem_we ? dmem_data : ram[dmem_addr[6:0]];

  dmem_access_unit #(.BUS_TIMEOUT(T)) dut (
    .clk(clk), .reset_n(reset_n),
    .cpu_addr(cpu_addr), .cpu_data(cpu_data), .cpu_we(cpu_we), .cpu_re(cpu_re),
    .cpu_q(cpu_q), .cpu_stall(cpu_stall), .bus_error(bus_error),
    .dmem_addr(dmem_addr), .dmem_we(dmem_we), .dmem_data(dmem_data), .dmem_q(dmem_q),
    .bus_addr(bus_addr), .bus_data(bus_data), .bus_we(bus_we),
    .bus_start(bus_start), .bus_done(bus_done), .bus_q(bus_q)
  );

  // Hit access: one cycle, no stall. Tasks start and end at posedge+1.
  task automatic hit_access(input logic [31:0] a, input logic [31:0] d,
                            input logic we, input logic re);
    cpu_addr = a; cpu_data = d; cpu_we = we; cpu_re = re;
    @(negedge clk);
    checks++;
    if (cpu_stall !== 1'b0) begin
      errors++; $display("FAIL hit_stall addr=%h got %b expected 0", a, cpu_stall);
    end
    checks++;
    if (dmem_we !== we) begin
      errors++; $display("FAIL hit_dmem_we addr=%h got %b expected %b", a, dmem_we, we);
    end
    if (!we && re) begin
      checks++;
      if (cpu_q !== ref_mem[a[6:0]]) begin
        errors++; $display("FAIL hit_load addr=%h got %h expected %h", a, cpu_q, ref_mem[a[6:0]]);
      end
    end
    if (we) ref_mem[a[6:0]] = d;
    @(posedge clk); #1;
  endtask

  // Miss access: slave answers dly cycles after bus_start (dly > T: never in time).
  task automatic miss_access(input logic [31:0] a, input logic [31:0] d,
                             input logic we, input logic re, input int dly,
                             input logic [31:0] rdata);
    int ke, starts;
    logic tmo;
    logic [31:0] exp_q;
    tmo    = (dly > T);
    ke     = 2 + (tmo ? T : dly);
    exp_q  = (we || tmo) ? 32'h0 : rdata;
    starts = 0;
    cpu_addr = a; cpu_data = d; cpu_we = we; cpu_re = re;
    for (int k = 0; k <= ke; k++) begin
      bus_done = (k == 1 + dly);
      bus_q    = (k == 1 + dly) ? rdata : $urandom;
      @(negedge clk);
      if (bus_start === 1'b1) starts++;
      checks++;
      if (cpu_stall !== (k < ke)) begin
        errors++; $display("FAIL miss_stall k=%0d got %b expected %b", k, cpu_stall, k < ke);
      end
      checks++;
      if (bus_start !== (k == 1)) begin
        errors++; $display("FAIL miss_start k=%0d got %b expected %b", k, bus_start, k == 1);
      end
      checks++;
      if (dmem_we !== 1'b0) begin
        errors++; $display("FAIL miss_dmem_we k=%0d got %b expected 0", k, dmem_we);
      end
      if (k >= 1) begin
        checks++;
        if (bus_addr !== a || bus_data !== d || bus_we !== we) begin
          errors++;
          $display("FAIL miss_capture k=%0d got %h/%h/%b expected %h/%h/%b",
                   k, bus_addr, bus_data, bus_we, a, d, we);
        end
      end
      checks++;
      if (bus_error !== ((k == ke) && tmo)) begin
        errors++; $display("FAIL miss_error k=%0d got %b expected %b", k, bus_error, (k == ke) && tmo);
      end
      if (k == ke) begin
        checks++;
        if (cpu_q !== exp_q) begin
          errors++; $display("FAIL miss_result addr=%h got %h expected %h", a, cpu_q, exp_q);
        end
      end
      @(posedge clk); #1;
    end
    bus_done = 1'b0;
    checks++;
    if (starts != 1) begin
      errors++; $display("FAIL miss_start_count addr=%h got %0d expected 1", a, starts);
    end
  endtask

  task automatic idle_cycles(input int n);
    logic [31:0] a;
    for (int i = 0; i < n; i++) begin
      a = {25'h0, 7'($urandom)};
      cpu_addr = a; cpu_data = $urandom; cpu_we = 1'b0; cpu_re = 1'b0;
      @(negedge clk);
      checks++;
      if (cpu_stall !== 1'b0 || bus_start !== 1'b0 || bus_error !== 1'b0) begin
        errors++; $display("FAIL idle_ctrl got stall=%b start=%b err=%b expected 0/0/0",
                           cpu_stall, bus_start, bus_error);
      end
      checks++;
      if (cpu_q !== ref_mem[a[6:0]]) begin
        errors++; $display("FAIL idle_q addr=%h got %h expected %h", a, cpu_q, ref_mem[a[6:0]]);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0; bus_done = 1'b0; bus_q = '0;
    cpu_addr = 32'h0040_0000; cpu_data = 32'h1111_2222; cpu_we = 1'b0; cpu_re = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if (cpu_stall !== 1'b0 || bus_start !== 1'b0 || bus_we !== 1'b0 || bus_error !== 1'b0 ||
        dmem_we !== 1'b0 || bus_addr !== 32'h0 || bus_data !== 32'h0) begin
      errors++;
      $display("FAIL reset_state got stall=%b start=%b we=%b err=%b dwe=%b addr=%h data=%h expected all 0",
               cpu_stall, bus_start, bus_we, bus_error, dmem_we, bus_addr, bus_data);
    end
    cpu_re = 1'b0;
    reset_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic fill_memory();
    for (int i = 0; i < 128; i++) hit_access(32'(i), $urandom, 1'b1, 1'b0);
  endtask

  task automatic test_hit_store_load();
    hit_access(32'd5, 32'hDEAD_BEEF, 1'b1, 1'b0);
    hit_access(32'd5, 32'h0, 1'b0, 1'b1);
    checks++;
    if (ref_mem[5] !== 32'hDEAD_BEEF || ram[5] !== 32'hDEAD_BEEF) begin
      errors++; $display("FAIL hit_mem5 got %h expected DEADBEEF", ram[5]);
    end
  endtask

  task automatic test_bus_load();
    miss_access(32'h0010_0000, 32'h0, 1'b0, 1'b1, 3, 32'h1234_5678);
    idle_cycles(1);
  endtask

  task automatic test_bus_store();
    miss_access(32'h0020_0004, 32'hCAFE_F00D, 1'b1, 1'b1, 2, 32'h5555_AAAA);
    idle_cycles(1);
  endtask

  task automatic test_timeout();
    miss_access(32'h0030_0010, 32'h0, 1'b0, 1'b1, 1000, 32'h0);
    idle_cycles(2);
    miss_access(32'h0030_0014, 32'h0, 1'b0, 1'b1, T, 32'h0BAD_F00D);
    miss_access(32'h0030_0018, 32'h0, 1'b0, 1'b1, T + 1, 32'h0BAD_F00D);
    idle_cycles(1);
  endtask

  task automatic test_reset_mid();
    cpu_addr = 32'h0030_0000; cpu_data = 32'h7777_8888; cpu_we = 1'b0; cpu_re = 1'b1;
    repeat (3) begin @(posedge clk); #1; end
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if (cpu_stall !== 1'b0 || bus_start !== 1'b0 || bus_we !== 1'b0 || bus_error !== 1'b0 ||
        dmem_we !== 1'b0 || bus_addr !== 32'h0 || bus_data !== 32'h0) begin
      errors++;
      $display("FAIL reset_mid got stall=%b start=%b we=%b err=%b dwe=%b addr=%h data=%h expected all 0",
               cpu_stall, bus_start, bus_we, bus_error, dmem_we, bus_addr, bus_data);
    end
    bus_done = 1'b1; bus_q = 32'hFFFF_0000; cpu_re = 1'b0;
    @(negedge clk); reset_n = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checks++;
      if (cpu_stall !== 1'b0 || bus_start !== 1'b0 || bus_error !== 1'b0) begin
        errors++; $display("FAIL reset_done_ignored i=%0d got stall=%b start=%b err=%b expected 0/0/0",
                           i, cpu_stall, bus_start, bus_error);
      end
      @(posedge clk); #1;
      bus_done = 1'b0;
    end
    hit_access(32'd9, 32'h600D_CAFE, 1'b1, 1'b0);
    hit_access(32'd9, 32'h0, 1'b0, 1'b1);
  endtask

  task automatic test_held_request();
    miss_access(32'h0050_0020, 32'h0, 1'b0, 1'b1, 1, 32'hABCD_0123);
    idle_cycles(3);
  endtask

  task automatic test_back_to_back();
    logic [31:0] a;
    int sel;
    logic we, re;
    for (int n = 0; n < 80; n++) begin
      sel = $urandom_range(0, 3);
      we = 1'($urandom); re = 1'($urandom);
      if (!we && !re) re = 1'b1;
      if (sel == 0) idle_cycles(1);
      else if (sel == 1) hit_access({25'h0, 7'($urandom)}, $urandom, we, re);
      else begin
        a = $urandom;
        if (a[31:7] == 25'h0) a[31] = 1'b1;
        miss_access(a, $urandom, we, re, $urandom_range(1, T + 3), $urandom);
      end
    end
    idle_cycles(1);
  endtask

  initial begin
    test_reset();
    fill_memory();
    test_hit_store_load();
    test_bus_load();
    test_bus_store();
    test_timeout();
    test_reset_mid();
    test_held_request();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/dmem_access_unit.md
Name: dmem_access_unit

Overview:
- Memory-stage front end sitting directly upstream of the 128x32 data memory.
- Decodes each CPU load/store address.
- Internal-range accesses go straight to the data memory with zero added latency.
- All other addresses become a start/done handshake transaction on the external bus. The pipeline is stalled until the transaction completes or times out.

Parameters:
- DMEM_BASE, 32'h00000000, base address of the internal data memory window; low DMEM_AW bits ignored.
- DMEM_AW, 7, address bits decoded by the data memory (window = 2^DMEM_AW words).
- BUS_TIMEOUT, 1023, max cycles in BUS_WAIT before a forced abort.

Ports:
- clk  in  1  single clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- cpu_addr  in  32  word address from the memory stage.
- cpu_data  in  32  store data.
- cpu_we  in  1  store request.
- cpu_re  in  1  load request.
- cpu_q  out  32  load result to writeback.
- cpu_stall  out  1  freeze pipeline.
- bus_error  out  1  one-cycle timeout flag.
- dmem_addr  out  32  to data memory addr.
- dmem_we  out  1  to data memory we.
- dmem_data  out  32  to data memory data.
- dmem_q  in  32  from data memory q; combinational, with write bypass.
- bus_addr  out  32  external address (registered).
- bus_data  out  32  external write data (registered).
- bus_we  out  1  external write (registered).
- bus_start  out  1  one-cycle transaction start.
- bus_done  in  1  transaction complete.
- bus_q  in  32  external read data, valid with bus_done.

Behaviour:
- Decode: hit = (cpu_addr[31:DMEM_AW] == DMEM_BASE[31:DMEM_AW]). req = cpu_we | cpu_re. If cpu_we and cpu_re are both high, the access is a write.
- dmem_addr = cpu_addr and dmem_data = cpu_data at all times.
- dmem_we = cpu_we & hit & (state==IDLE). It is never asserted for a miss.
- Hit path (state IDLE): cpu_q = dmem_q combinationally, cpu_stall = 0. Zero added latency; a store followed by a load to the same address the next cycle returns the new data.
- FSM states: IDLE, BUS_REQ, BUS_WAIT, DONE.
- IDLE, req & ~hit:
  - cpu_stall = 1 combinationally.
  - Register cpu_addr, cpu_data and the write flag into bus_addr, bus_data and bus_we.
  - Next state BUS_REQ.
- BUS_REQ:
  - bus_start = 1 for exactly this cycle; cpu_stall = 1.
  - Clear the timeout counter.
  - Next state BUS_WAIT.
- BUS_WAIT:
  - cpu_stall = 1; bus_done is sampled only in this state.
  - On bus_done: result <= (bus_we ? 0 : bus_q), next state DONE.
  - Otherwise the counter increments. When the counter == BUS_TIMEOUT-1 without done: result <= 0, timeout flag set, next state DONE.
- DONE:
  - cpu_stall = 0; cpu_q = result; bus_error = timeout flag.
  - Next state IDLE unconditionally. A request still present on the inputs during DONE is not re-issued.
  - Clear the timeout flag on exit.
- bus_addr, bus_data and bus_we hold their values from IDLE capture until the next capture.
- Miss latency: request in cycle N; bus_start in N+1; earliest bus_done in N+2; data on cpu_q with stall low in N+3. Stall is high for cycles N..N+2 plus any wait cycles.
- No request (req=0): stall 0; cpu_q = dmem_q in IDLE.
- Counter width: clog2(BUS_TIMEOUT+1); it saturates and never wraps.
- Reset (asserted any time, including mid-transaction):
  - Immediately: state=IDLE, bus_start=0, bus_we=0, bus_addr=0, bus_data=0, result=0, counter=0, bus_error=0, dmem_we=0, cpu_stall=0.
  - A bus_done arriving after reset is ignored.

Test Plan:
- Reset, then store 32'hDEADBEEF to addr 5 and load addr 5 the next cycle -> dmem_we=1 in the store cycle; the load returns DEADBEEF with cpu_stall never high.
- Load addr 32'h00100000; slave asserts bus_done with bus_q=32'h12345678 three cycles after bus_start -> bus_start high exactly one cycle; stall high 5 cycles; cpu_q=12345678 in DONE with stall low.
- Store 32'hCAFEF00D to 32'h00200004 with cpu_re also high -> bus_we=1, bus_addr=00200004, bus_data=CAFEF00D; dmem_we stays 0; cpu_q=0 in DONE.
- BUS_TIMEOUT=8, external load, slave never responds -> stall released after BUS_TIMEOUT wait cycles; cpu_q=0; bus_error pulses one cycle.
- External load with reset_n dropped while in BUS_WAIT, then bus_done pulsed -> all outputs return to reset values immediately; done ignored; the next hit access completes normally.
- Request held stable through DONE -> exactly one bus_start per request; FSM returns to IDLE.
